falafel_input_demux: RTL
========================

# falafel_input_demux

Parametrised front-end request demultiplexer for the falafel accelerator. It parses a single serial stream of 2-beat messages (header, then payload) and routes each payload, tagged with its message ID, into one of `NUM_CH` independently buffered output channels or onto a registered config-register write port. It extends the fixed alloc/free parser with a configurable channel count and FIFO depth, per-channel occupancy reporting, and detection and counting of illegal opcodes. It sits between the host request interface and the allocator/free engines.

## Interface
- `DATA_W`, 64, width of every input beat and payload
- `ID_W`, 8, message ID width
- `OPCODE_W`, 4, opcode field width; must satisfy 2^OPCODE_W >= NUM_CH+1
- `REG_ADDR_W`, 16, config-register address width
- `NUM_CH`, 2, number of output request channels (>=1)
- `FIFO_DEPTH`, 4, entries per channel FIFO (>=2, power of 2)
- `clk_i  in  1  clock; all logic on rising edge`
- `rst_i  in  1  synchronous, active-high reset`
- `req_val_i  in  1  input beat valid`
- `req_rdy_o  out  1  input beat ready`
- `req_data_i  in  DATA_W  input beat`
- `ch_val_o  out  NUM_CH  per-channel entry valid`
- `ch_rdy_i  in  NUM_CH  per-channel consumer ready`
- `ch_data_o  out  NUM_CH*(ID_W+DATA_W)  channel c at slice c; entry = {id, payload}`
- `ch_level_o  out  NUM_CH*$clog2(FIFO_DEPTH+1)  per-channel FIFO occupancy`
- `cfg_wr_o  out  1  config write strobe (1 cycle)`
- `cfg_addr_o  out  REG_ADDR_W  config address`
- `cfg_data_o  out  DATA_W  config data`
- `err_o  out  1  illegal-opcode pulse (1 cycle)`
- `err_count_o  out  16  saturating illegal-opcode count`

## Operation
- Header layout: opcode = [OPCODE_W-1:0]; id = [OPCODE_W+ID_W-1:OPCODE_W]; addr = [OPCODE_W+ID_W+REG_ADDR_W-1:OPCODE_W+ID_W]; all other bits are ignored.
- Opcode c < NUM_CH: channel-c request. Opcode == NUM_CH: config write. Any other value: illegal.
- FSM states:
  - HDR: `req_rdy_o`=1. On handshake, latch id, addr and the target channel. Channel opcode → DATA. Config opcode → CFG. Illegal opcode → stay in HDR and assert `err_o` the next cycle; the beat is dropped.
  - DATA: `req_rdy_o` = !full[target]. On handshake, push {id, req_data_i} into FIFO[target] and go to HDR.
  - CFG: `req_rdy_o`=1. On handshake, register addr and data, pulse `cfg_wr_o` the next cycle, and go to HDR.
- Each channel FIFO is independent. `ch_val_o[c]` = !empty[c]. Pop on `ch_val_o[c] && ch_rdy_i[c]`. `ch_data_o` shows the head entry.
- Simultaneous push and pop on a non-empty FIFO: level unchanged, order preserved.
- Full FIFO: `req_rdy_o` stays low in DATA even if a pop happens in the same cycle (no bypass). The stall affects only the input stream; other channels keep draining.
- Read and write pointers wrap modulo FIFO_DEPTH.
- `err_count_o` increments on every illegal header and saturates at 16'hFFFF.
- Reset mid-message: a partially received request is discarded, all FIFOs are flushed, and the FSM returns to HDR.

## Timing
- Reset values:
  - `req_rdy_o`=1 (FSM in HDR)
  - `ch_val_o`=0, `ch_level_o`=0, `ch_data_o`=0
  - `cfg_wr_o`=0, `cfg_addr_o`=0, `cfg_data_o`=0
  - `err_o`=0, `err_count_o`=0
- Header accepted at cycle t → payload can be accepted at t+1 at the earliest.
- Payload accepted at cycle t → `ch_val_o[c]`=1 and `ch_level_o` updated at t+1 (no fall-through).
- Config payload accepted at cycle t → `cfg_wr_o`=1 with valid addr/data at t+1, for exactly one cycle. `cfg_addr_o`/`cfg_data_o` hold until the next config write.
- Illegal header at cycle t → `err_o`=1 and count+1 at t+1.
- Peak input throughput: one message per 2 cycles.
- `req_rdy_o` is combinational from state and FIFO full flags only. It never depends on `req_val_i`.

## Test plan
- NUM_CH=3: headers op=0 id=5, op=2 id=9, each followed by payload 64'hA/64'hB → ch0 gets {5,A}, ch2 gets {9,B}, ch1 stays empty; both valid one cycle after their payload beat.
- FIFO_DEPTH=4, `ch_rdy_i[0]`=0, five op=0 messages → 4 accepted, `ch_level_o[0]`=4, `req_rdy_o`=0 during the 5th payload. Raising `ch_rdy_i[0]` drains in order and the 5th payload is then accepted.
- Config header op=NUM_CH, addr=16'h0010, payload 64'hDEAD → `cfg_wr_o` pulses once with addr 0x10 and data 0xDEAD.
- Illegal op=15 header followed by a valid op=1 message → `err_o` one pulse, `err_count_o`=1, ch1 receives the request correctly. Force the count to 16'hFFFF, send another illegal header → count stays at 16'hFFFF.
- Assert `rst_i` after a channel header but before its payload, with FIFOs non-empty → all levels 0, state HDR; the next beat is parsed as a header.
- Random mixed opcodes with random `ch_rdy_i` against a scoreboard → per-channel order and contents match, with no loss or duplication.

Source files
------------

// File: rtl/falafel_input_demux.sv
// falafel_input_demux
//   Front-end request demultiplexer. Parses a serial stream of 2-beat
//   messages (header, payload) and steers each payload, tagged with the
//   header's message ID, into one of NUM_CH buffered request channels or
//   onto a registered config-register write port. Illegal opcodes are
//   dropped, flagged with a one-cycle pulse and counted (saturating).
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_val_i/rdy_o    input beat handshake, req_data_i beat contents
//   ch_val_o/ch_rdy_i  per-channel head valid / consumer ready
//   ch_data_o          per-channel head entry {id, payload}, channel c at slice c
//   ch_level_o         per-channel FIFO occupancy
//   cfg_wr_o           one-cycle config write strobe, cfg_addr_o/cfg_data_o held
//   err_o              one-cycle illegal-opcode pulse
//   err_count_o        saturating illegal-opcode count

// Per-channel FIFO. Head entry reads as zero while empty so the channel
// output is clean out of reset without clearing the storage array.
module falafel_ch_fifo #(
  parameter int ENT_W = 72,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [ENT_W-1:0] din,
  input  logic             rdy,
  output logic             val,
  output logic [ENT_W-1:0] dout,
  output logic             full,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [LVL_W-1:0] cnt;
  logic             pop;

  assign val   = (cnt != '0);
  assign full  = (cnt == LVL_W'(DEPTH));
  assign pop   = val && rdy;
  assign dout  = val ? mem[rd_ptr] : '0;
  assign level = cnt;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

module falafel_input_demux #(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 8,
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         req_val_i,
  output logic                                         req_rdy_o,
  input  logic [DATA_W-1:0]                            req_data_i,
  output logic [NUM_CH-1:0]                            ch_val_o,
  input  logic [NUM_CH-1:0]                            ch_rdy_i,
  output logic [NUM_CH*(ID_W+DATA_W)-1:0]              ch_data_o,
  output logic [NUM_CH*$clog2(FIFO_DEPTH+1)-1:0]       ch_level_o,
  output logic                                         cfg_wr_o,
  output logic [REG_ADDR_W-1:0]                        cfg_addr_o,
  output logic [DATA_W-1:0]                            cfg_data_o,
  output logic                                         err_o,
  output logic [15:0]                                  err_count_o
);
  localparam int ENT_W = ID_W + DATA_W;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int HDR_W = OPCODE_W + ID_W + REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [ID_W-1:0]       id;
    logic [OPCODE_W-1:0]   op;
  } hdr_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] payload;
  } ent_t;

  typedef enum logic [1:0] {S_HDR, S_DATA, S_CFG} state_t;

  state_t state_q, state_d;
  hdr_t   hdr;
  logic   is_ch, is_cfg, illegal;
  logic   accept_hdr, accept_pl, accept_cfg;
  logic   tgt_full;

  logic [OPCODE_W-1:0]   tgt_q;
  logic [ID_W-1:0]       id_q;
  logic [REG_ADDR_W-1:0] addr_q;
  ent_t                  push_ent;

  logic [NUM_CH-1:0]            push, full;
  logic [NUM_CH-1:0][ENT_W-1:0] ch_data;
  logic [NUM_CH-1:0][LVL_W-1:0] ch_level;

  // Bits above the addr field are don't-care.
  assign hdr     = hdr_t'(req_data_i[HDR_W-1:0]);
  assign is_ch   = (hdr.op < OPCODE_W'(NUM_CH));
  assign is_cfg  = (hdr.op == OPCODE_W'(NUM_CH));
  assign illegal = !is_ch && !is_cfg;

  // Full flag of the channel the pending payload is headed for.
  always_comb begin
    tgt_full = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (tgt_q == OPCODE_W'(c)) tgt_full = full[c];
  end

  assign accept_hdr = (state_q == S_HDR)  && req_val_i;
  assign accept_pl  = (state_q == S_DATA) && req_val_i && !tgt_full;
  assign accept_cfg = (state_q == S_CFG)  && req_val_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_HDR;
    else       state_q <= state_d;
  end

  // req_rdy_o depends on state and full flags only, never on req_val_i.
  always_comb begin
    state_d   = state_q;
    req_rdy_o = 1'b1;
    case (state_q)
      S_HDR: begin
        if (req_val_i) begin
          if (is_ch)       state_d = S_DATA;
          else if (is_cfg) state_d = S_CFG;
        end
      end
      S_DATA: begin
        req_rdy_o = !tgt_full;
        if (req_val_i && !tgt_full) state_d = S_HDR;
      end
      S_CFG: begin
        if (req_val_i) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt_q       <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      cfg_wr_o    <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else begin
      if (accept_hdr) begin
        tgt_q  <= hdr.op;
        id_q   <= hdr.id;
        addr_q <= hdr.addr;
      end
      cfg_wr_o <= accept_cfg;
      if (accept_cfg) begin
        cfg_addr_o <= addr_q;
        cfg_data_o <= req_data_i;
      end
      err_o <= accept_hdr && illegal;
      if (accept_hdr && illegal && (err_count_o != 16'hFFFF))
        err_count_o <= err_count_o + 16'd1;
    end
  end

  assign push_ent.id      = id_q;
  assign push_ent.payload = req_data_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = accept_pl && (tgt_q == OPCODE_W'(c));

    falafel_ch_fifo #(
      .ENT_W (ENT_W),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
    ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push[c]),
      .din   (push_ent),
      .rdy   (ch_rdy_i[c]),
      .val   (ch_val_o[c]),
      .dout  (ch_data[c]),
      .full  (full[c]),
      .level (ch_level[c])
    );
  end

  assign ch_data_o  = ch_data;
  assign ch_level_o = ch_level;
endmodule
